// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and constants for the memory-stage load/store unit.
// Holds the FSM state encoding, the funct3 access codes, bus widths and the
// alignment check used by both the request path and the load formatter.
package lsu_pkg;

  localparam int XLEN   = 32;
  localparam int STRB_W = XLEN / 8;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Reserved funct3 encodings fall into the word case, so they carry the
  // word alignment rule as well.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
    case (f3)
      F3_B, F3_BU: return 1'b0;
      F3_H, F3_HU: return a[0];
      default:     return (a != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: byte-lane formatting for the LSU (purely combinational).
// Latency: 0 cycles. Backpressure: none, no state.
// Store side (i_st_*): replicates store data across lanes, builds byte strobes.
// Load side  (i_ld_*): picks the addressed byte/half of i_rword and extends it.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]        i_st_funct3,
  input  logic [1:0]        i_st_addr_lo,
  input  logic [XLEN-1:0]   i_st_data,
  output logic [XLEN-1:0]   o_st_wdata,
  output logic [STRB_W-1:0] o_st_wstrb,
  input  logic [2:0]        i_ld_funct3,
  input  logic [1:0]        i_ld_addr_lo,
  input  logic [XLEN-1:0]   i_ld_rword,
  output logic [XLEN-1:0]   o_ld_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    o_st_wdata = i_st_data;
    o_st_wstrb = 4'b1111;
    case (i_st_funct3)
      F3_B, F3_BU: begin
        o_st_wdata = {4{i_st_data[7:0]}};
        o_st_wstrb = 4'b0001 << i_st_addr_lo;
      end
      F3_H, F3_HU: begin
        o_st_wdata = {2{i_st_data[15:0]}};
        o_st_wstrb = i_st_addr_lo[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        o_st_wdata = i_st_data;
        o_st_wstrb = 4'b1111;
      end
    endcase
  end

  always_comb begin
    w_byte = i_ld_rword[7:0];
    case (i_ld_addr_lo)
      2'd0:    w_byte = i_ld_rword[7:0];
      2'd1:    w_byte = i_ld_rword[15:8];
      2'd2:    w_byte = i_ld_rword[23:16];
      default: w_byte = i_ld_rword[31:24];
    endcase
  end

  assign w_half = i_ld_addr_lo[1] ? i_ld_rword[31:16] : i_ld_rword[15:0];

  always_comb begin
    o_ld_data = i_ld_rword;
    case (i_ld_funct3)
      F3_B:    o_ld_data = {{24{w_byte[7]}}, w_byte};
      F3_BU:   o_ld_data = {24'b0, w_byte};
      F3_H:    o_ld_data = {{16{w_half[15]}}, w_half};
      F3_HU:   o_ld_data = {16'b0, w_half};
      default: o_ld_data = i_ld_rword;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// mem_lsu: MEM-stage load/store unit bridging the pipeline to a wait-state data bus.
// Latency: IDLE -> BUSY (>=1 cycle) -> DONE; 2 stall cycles at zero wait, +1 per wait state.
// Backpressure: StallM holds the upstream pipeline until the bus answers or TIMEOUT expires.
// Ports: clk/reset; MemReadM, MemWriteM, funct3M, ALUResultM, WriteDataM from EX_MEM;
//        ReadDataM, StallM, MisalignM, BusErrM to the pipeline; dmem_* data-memory bus.
module mem_lsu
  import lsu_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemReadM,
  input  logic              MemWriteM,
  input  logic [2:0]        funct3M,
  input  logic [XLEN-1:0]   ALUResultM,
  input  logic [XLEN-1:0]   WriteDataM,
  output logic [XLEN-1:0]   ReadDataM,
  output logic              StallM,
  output logic              MisalignM,
  output logic              BusErrM,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [XLEN-1:0]   dmem_addr,
  output logic [XLEN-1:0]   dmem_wdata,
  output logic [STRB_W-1:0] dmem_wstrb,
  input  logic              dmem_ready,
  input  logic [XLEN-1:0]   dmem_rdata
);

  localparam int              CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t              r_state;
  state_t              w_next;
  logic [XLEN-1:0]     r_addr;
  logic [2:0]          r_funct3;
  logic                r_we;
  logic [XLEN-1:0]     r_wdata;
  logic [STRB_W-1:0]   r_wstrb;
  logic [XLEN-1:0]     r_rdata;
  logic                r_err;
  logic [CNT_W-1:0]    r_cnt;

  logic                w_mem_op;
  logic                w_misalign;
  logic                w_access;
  logic                w_timeout;
  logic                w_latch;
  logic                w_stall;
  logic                w_busy;
  logic [XLEN-1:0]     w_st_wdata;
  logic [STRB_W-1:0]   w_st_wstrb;
  logic [XLEN-1:0]     w_ld_data;

  assign w_mem_op   = MemReadM | MemWriteM;
  assign w_misalign = w_mem_op & is_misaligned(funct3M, ALUResultM[1:0]);
  assign w_access   = w_mem_op & ~w_misalign;
  // Last permitted BUSY cycle with no answer; a ready in that same cycle still wins.
  assign w_timeout  = (r_cnt == CNT_LAST) & ~dmem_ready;
  assign w_busy     = (r_state == BUSY);

  lsu_align u_align (
    .i_st_funct3  (funct3M),
    .i_st_addr_lo (ALUResultM[1:0]),
    .i_st_data    (WriteDataM),
    .o_st_wdata   (w_st_wdata),
    .o_st_wstrb   (w_st_wstrb),
    .i_ld_funct3  (r_funct3),
    .i_ld_addr_lo (r_addr[1:0]),
    .i_ld_rword   (r_rdata),
    .o_ld_data    (w_ld_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_stall = 1'b0;
    w_latch = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_access) begin
          w_next  = BUSY;
          w_stall = 1'b1;
          w_latch = 1'b1;
        end
      end
      BUSY: begin
        w_stall = 1'b1;
        if (dmem_ready || w_timeout) w_next = DONE;
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_addr   <= '0;
      r_funct3 <= '0;
      r_we     <= 1'b0;
      r_wdata  <= '0;
      r_wstrb  <= '0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
      r_cnt    <= '0;
    end else begin
      if (w_latch) begin
        r_addr   <= ALUResultM;
        r_funct3 <= funct3M;
        r_we     <= MemWriteM;
        r_wdata  <= w_st_wdata;
        r_wstrb  <= MemWriteM ? w_st_wstrb : '0;
        r_rdata  <= '0;
        r_err    <= 1'b0;
        r_cnt    <= '0;
      end
      if (w_busy) begin
        if (dmem_ready) begin
          if (!r_we) r_rdata <= dmem_rdata;
          r_cnt <= '0;
        end else if (w_timeout) begin
          r_err <= 1'b1;
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end
    end
  end

  // The IDLE stall is a combinational function of the EX_MEM inputs, so it is
  // masked by reset to let the pipeline unfreeze while reset is held.
  assign StallM    = w_stall & ~reset;
  assign MisalignM = (r_state == IDLE) & w_misalign;
  assign BusErrM   = (r_state == DONE) & r_err;
  assign ReadDataM = ((r_state == DONE) && !r_we && !r_err) ? w_ld_data : '0;

  // Bus fields are only driven while a request is outstanding.
  assign dmem_req   = w_busy;
  assign dmem_we    = w_busy & r_we;
  assign dmem_addr  = w_busy ? {r_addr[XLEN-1:2], 2'b00} : '0;
  assign dmem_wdata = w_busy ? r_wdata : '0;
  assign dmem_wstrb = w_busy ? r_wstrb : '0;

endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: directed-vector bench for mem_lsu (TIMEOUT=4) with hand-computed expectations.
module tb_mem_lsu;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        MemReadM, MemWriteM;
  logic [2:0]  funct3M;
  logic [31:0] ALUResultM, WriteDataM, ReadDataM;
  logic        StallM, MisalignM, BusErrM;
  logic        dmem_req, dmem_we, dmem_ready;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_wstrb;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int          stalls;
    int          reqs;
    int          berrs;
    logic        first_stall;
    logic        mis;
    logic        stable;
    logic        timed_out;
    logic [31:0] rdm;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic        we;
  } res_t;

  res_t r;

  mem_lsu #(.TIMEOUT(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .MemReadM   (MemReadM),
    .MemWriteM  (MemWriteM),
    .funct3M    (funct3M),
    .ALUResultM (ALUResultM),
    .WriteDataM (WriteDataM),
    .ReadDataM  (ReadDataM),
    .StallM     (StallM),
    .MisalignM  (MisalignM),
    .BusErrM    (BusErrM),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_wstrb (dmem_wstrb),
    .dmem_ready (dmem_ready),
    .dmem_rdata (dmem_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    MemReadM   = 1'b0;
    MemWriteM  = 1'b0;
    funct3M    = 3'b000;
    ALUResultM = 32'h0;
    WriteDataM = 32'h0;
    dmem_ready = 1'b0;
    dmem_rdata = 32'h0;
  endtask

  // Drives one access from IDLE, answers the bus after 'waits' wait states
  // (negative = never), and returns once the first non-stalled cycle is seen.
  task automatic do_access(input logic rd, input logic wr, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wd,
                           input logic [31:0] rdat, input int waits, output res_t o);
    logic fin;
    fin        = 1'b0;
    o          = '{default: 0};
    o.stable   = 1'b1;
    MemReadM   = rd;
    MemWriteM  = wr;
    funct3M    = f3;
    ALUResultM = addr;
    WriteDataM = wd;
    dmem_rdata = rdat;
    dmem_ready = 1'b0;
    for (int c = 0; c < 64; c++) begin
      #1;
      if (c == 0) begin
        o.first_stall = StallM;
        o.mis         = MisalignM;
      end
      if (dmem_req) begin
        if (o.reqs == 0) begin
          o.addr  = dmem_addr;
          o.wdata = dmem_wdata;
          o.strb  = dmem_wstrb;
          o.we    = dmem_we;
        end else if (dmem_addr !== o.addr || dmem_wdata !== o.wdata ||
                     dmem_wstrb !== o.strb || dmem_we !== o.we) begin
          o.stable = 1'b0;
        end
        o.reqs++;
        dmem_ready = (waits >= 0) && (o.reqs == waits + 1);
      end else begin
        dmem_ready = 1'b0;
      end
      if (BusErrM) o.berrs++;
      if (StallM) o.stalls++;
      else begin
        o.rdm = ReadDataM;
        fin   = 1'b1;
      end
      tick();
      if (fin) break;
    end
    dmem_ready  = 1'b0;
    o.timed_out = ~fin;
  endtask

  initial begin
    idle();
    #1;
    check("rst_req",   32'(dmem_req),   32'h0);
    check("rst_we",    32'(dmem_we),    32'h0);
    check("rst_addr",  dmem_addr,       32'h0);
    check("rst_wdata", dmem_wdata,      32'h0);
    check("rst_wstrb", 32'(dmem_wstrb), 32'h0);
    check("rst_rdata", ReadDataM,       32'h0);
    check("rst_berr",  32'(BusErrM),    32'h0);
    check("rst_stall", 32'(StallM),     32'h0);
    tick();
    tick();
    reset = 1'b0;

    // LB 0x103, zero wait
    do_access(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF_0000, 0, r);
    check("lb_done",   32'(r.timed_out), 32'h0);
    check("lb_stalls", 32'(r.stalls),    32'd2);
    check("lb_reqs",   32'(r.reqs),      32'd1);
    check("lb_addr",   r.addr,           32'h100);
    check("lb_we",     32'(r.we),        32'h0);
    check("lb_strb",   32'(r.strb),      32'h0);
    check("lb_data",   r.rdm,            32'hFFFF_FF80);
    idle();

    // SH 0x202, three wait states
    do_access(1'b0, 1'b1, 3'b001, 32'h202, 32'h1234_ABCD, 32'h5555_5555, 3, r);
    check("sh_stalls", 32'(r.stalls), 32'd5);
    check("sh_reqs",   32'(r.reqs),   32'd4);
    check("sh_stable", 32'(r.stable), 32'h1);
    check("sh_addr",   r.addr,        32'h200);
    check("sh_wdata",  r.wdata,       32'hABCD_ABCD);
    check("sh_strb",   32'(r.strb),   32'hC);
    check("sh_we",     32'(r.we),     32'h1);
    check("sh_rdata0", r.rdm,         32'h0);
    idle();

    // LW 0x301 misaligned
    do_access(1'b1, 1'b0, 3'b010, 32'h301, 32'h0, 32'h0, 0, r);
    check("lw_mis",    32'(r.mis),         32'h1);
    check("lw_stall",  32'(r.first_stall), 32'h0);
    check("lw_reqs",   32'(r.reqs),        32'd0);
    check("lw_rdata0", r.rdm,              32'h0);
    #1;
    check("lw_noreq",  32'(dmem_req),      32'h0);
    idle();

    // LH 0x001 misaligned, LH 0x002 aligned
    MemReadM = 1'b1; funct3M = 3'b001; ALUResultM = 32'h1;
    #1;
    check("lh_mis",    32'(MisalignM), 32'h1);
    ALUResultM = 32'h2;
    #1;
    check("lh_ok",     32'(MisalignM), 32'h0);
    idle();
    tick();

    // Timeout: ready never comes
    do_access(1'b1, 1'b0, 3'b010, 32'h40, 32'h0, 32'hFFFF_FFFF, -1, r);
    check("to_reqs",   32'(r.reqs),   32'd4);
    check("to_stalls", 32'(r.stalls), 32'd5);
    check("to_berr",   32'(r.berrs),  32'd1);
    check("to_rdata0", r.rdm,         32'h0);
    idle();
    #1;
    check("to_pulse",  32'(BusErrM),  32'h0);
    tick();

    // Ready on the last permitted BUSY cycle still completes normally
    do_access(1'b1, 1'b0, 3'b010, 32'h44, 32'h0, 32'hCAFE_F00D, 3, r);
    check("edge_berr", 32'(r.berrs), 32'd0);
    check("edge_reqs", 32'(r.reqs),  32'd4);
    check("edge_data", r.rdm,        32'hCAFE_F00D);
    idle();

    // SB 0x101
    do_access(1'b0, 1'b1, 3'b000, 32'h101, 32'h7777_775A, 32'h0, 1, r);
    check("sb_wdata",  r.wdata,      32'h5A5A_5A5A);
    check("sb_strb",   32'(r.strb),  32'h2);
    idle();

    // LH 0x000 sign-extended
    do_access(1'b1, 1'b0, 3'b001, 32'h0, 32'h0, 32'h1234_8001, 0, r);
    check("lh_data",   r.rdm,        32'hFFFF_8001);
    idle();

    // Reserved funct3 acts as word
    do_access(1'b1, 1'b0, 3'b011, 32'h8, 32'h0, 32'h1122_3344, 0, r);
    check("rsv_data",  r.rdm,        32'h1122_3344);
    idle();

    // Reset asserted mid-BUSY
    MemReadM = 1'b1; funct3M = 3'b010; ALUResultM = 32'h10;
    tick();
    check("rb_req",    32'(dmem_req), 32'h1);
    reset = 1'b1;
    #1;
    check("rb_req0",   32'(dmem_req), 32'h0);
    check("rb_stall0", 32'(StallM),   32'h0);
    tick();
    idle();
    reset = 1'b0;
    do_access(1'b1, 1'b0, 3'b101, 32'h2, 32'h0, 32'hBEEF_0000, 0, r);
    check("lhu_idle",  32'(r.first_stall), 32'h1);
    check("lhu_stall", 32'(r.stalls),      32'd2);
    check("lhu_data",  r.rdm,              32'h0000_BEEF);
    idle();

    // Back-to-back LBU 0x0 then SW 0x4
    do_access(1'b1, 1'b0, 3'b100, 32'h0, 32'h0, 32'h0000_00F0, 0, r);
    check("lbu_data",  r.rdm,        32'h0000_00F0);
    do_access(1'b0, 1'b1, 3'b010, 32'h4, 32'hDEAD_BEEF, 32'h0, 0, r);
    check("sw_idle",   32'(r.first_stall), 32'h1);
    check("sw_stalls", 32'(r.stalls),      32'd2);
    check("sw_addr",   r.addr,             32'h4);
    check("sw_strb",   32'(r.strb),        32'hF);
    check("sw_wdata",  r.wdata,            32'hDEAD_BEEF);
    idle();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
